b_lut_rom_arbiter: RTL
======================

# b_lut_rom_arbiter

Round-robin arbiter that shares the single-port B_LUT coefficient ROM between up to `NUM_REQ` requesters. Each requester gets a one-hot grant and a tagged response. The block sits between the voice-processing filter stages and the ROM wrapper. It drives the ROM address, clock-enable and output-register enable, and tracks each read through the ROM's fixed read latency so the returned word reaches the requester that issued it.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters, 2..8
- `ADDR_WIDTH`, 10, ROM address width; matches the ROM wrapper's `c_ADDR_WIDTH`
- `DATA_WIDTH`, 32, ROM word width; matches the ROM wrapper's `c_DATA_WIDTH`
- `RD_LATENCY`, 1, ROM read latency in cycles: 1 means no output register, 2 means the output register is enabled

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1  single clock for the arbiter and the ROM
- `rst`  in  1  asynchronous, active-high reset
- `en`  in  1  arbitration enable; when low, no new grants are issued and in-flight reads still complete
- `req`  in  NUM_REQ  per-requester read request; held until granted
- `req_addr`  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- `gnt`  out  NUM_REQ  one-hot, combinational; the address is accepted in this cycle
- `rsp_valid`  out  NUM_REQ  one-hot, registered; `rsp_data` belongs to the flagged requester
- `rsp_data`  out  DATA_WIDTH  read data, taken directly from `rom_rd_data`
- `busy`  out  1  high while any read is in flight
- `rom_addr`  out  ADDR_WIDTH  address to the ROM
- `rom_clk_en`  out  1  ROM clock enable
- `rom_rd_oce`  out  1  ROM output-register enable
- `rom_rd_data`  in  DATA_WIDTH  data from the ROM

## Operation
- Arbitration is combinational over `req & {NUM_REQ{en}}`. Search starts at `ptr` and moves upward, wrapping modulo `NUM_REQ`. The first asserted request wins.
- `ptr` is a register, reset to 0. After a grant to requester i, `ptr` becomes (i+1) mod NUM_REQ. With no grant, `ptr` holds.
- Grant cycle: `gnt[i]`=1, `rom_addr` = address of requester i, `rom_clk_en`=1. With no grant, `rom_addr` = 0.
- Requester handshake:
  - On seeing `gnt[i]`, the requester may drop `req[i]` or change `req_addr` for the next cycle.
  - `req` must not be withdrawn before it is granted; behaviour is undefined if it is.
- Tag pipeline:
  - Depth `RD_LATENCY`. Each stage holds a one-hot `NUM_REQ`-bit tag.
  - Stage 0 loads `gnt` every cycle, including all-zero.
  - The last stage drives `rsp_valid`.
- `rom_clk_en` = any grant OR any non-zero tag stage, so the ROM pipeline advances while reads are in flight.
- `rom_rd_oce`:
  - RD_LATENCY=2: equals the stage-0 tag being non-zero.
  - RD_LATENCY=1: tied to 0.
- `busy` = OR of all tag-stage bits.
- Throughput is one read per cycle. Back-to-back grants to the same requester are allowed only when it is the sole requester.
- `en` falling mid-stream: grants stop in that cycle; outstanding tags drain normally.

## Timing
- Reset values: `gnt`=0, `rsp_valid`=0, all tag stages = 0, `ptr`=0, `busy`=0, `rom_addr`=0, `rom_clk_en`=0, `rom_rd_oce`=0.
- `rsp_data` is not reset; it is valid only when `rsp_valid` is non-zero.
- Latency from `gnt[i]` at cycle T to `rsp_valid[i]`:
  - cycle T+1 for RD_LATENCY=1
  - cycle T+2 for RD_LATENCY=2
- `rsp_valid` is a single-cycle pulse per grant. At most one bit is set.
- All requests simultaneous: grants follow ptr, ptr+1, … in consecutive cycles, so no requester waits more than NUM_REQ-1 cycles.
- Reset asserted mid-operation:
  - All in-flight tags clear immediately (asynchronous).
  - No `rsp_valid` is produced for reads granted before reset.
  - After release, `ptr` restarts at 0.
- A new request arriving in the same cycle as a grant to another requester is considered from the next cycle.

## Test plan
- RD_LATENCY=1, ROM word at address 0x005 = 0xDEADBEEF. `req[2]`=1 with addr 0x005 at cycle T → `gnt`=4'b0100 at T; `rsp_valid`=4'b0100 and `rsp_data`=0xDEADBEEF at T+1.
- RD_LATENCY=2, all four requesters request from reset (ptr=0), each held until granted → grants 0,1,2,3 at T..T+3; `rsp_valid` for 0..3 at T+2..T+5; `rom_rd_oce`=1 at T+1..T+4; `busy` falls after T+5.
- Fairness: `req[0]` and `req[3]` held continuously for 8 cycles → grants alternate 0,3,0,3,…; never two consecutive grants to the same requester.
- `en` dropped one cycle after two grants with RD_LATENCY=2 → no further `gnt`; both responses still appear 2 cycles after their grants; `busy` then falls to 0.
- `rst` pulsed one cycle after a grant, RD_LATENCY=2 → no `rsp_valid` for that grant; `ptr`=0 afterwards; the next simultaneous `req[1]`/`req[2]` grants requester 1 first.
- Single requester `req[1]` held for 5 cycles with incrementing addresses → 5 consecutive grants; 5 consecutive `rsp_valid[1]` pulses with matching ROM data in order.

Source files
------------

// File: rtl/b_lut_rom_arbiter_if.sv
// b_lut_rom_arbiter_if: requester/ROM bundle between filter stages, arbiter and B_LUT ROM wrapper
interface b_lut_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic en;
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic busy;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic rom_clk_en;
  logic rom_rd_oce;
  logic [DATA_WIDTH-1:0] rom_rd_data;
  modport master (
    output en, req, req_addr, rom_rd_data,
    input gnt, rsp_valid, rsp_data, busy, rom_addr, rom_clk_en, rom_rd_oce
  );
  modport slave (
    input en, req, req_addr, rom_rd_data,
    output gnt, rsp_valid, rsp_data, busy, rom_addr, rom_clk_en, rom_rd_oce
  );
endinterface

// File: rtl/b_lut_rom_arbiter.sv
// b_lut_rom_arbiter: round-robin sharing of the single-port B_LUT ROM with tags tracking each read to its requester
module b_lut_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  b_lut_rom_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW:0] NR = NUM_REQ[PW:0];
  logic [PW-1:0] ptr_q, ptr_d, off, win;
  logic [PW:0] sum, nxt;
  logic found;
  logic [NUM_REQ-1:0] act, gnt;
  logic [2*NUM_REQ-1:0] rot;
  logic [RD_LATENCY-1:0][NUM_REQ-1:0] tag_q, tag_d;
  assign act = bus.req & {NUM_REQ{bus.en & ~rst}};
  assign rot = {act, act} >> ptr_q;
  // pick the first active request at or above ptr, wrapping; advance ptr past the winner
  always_comb begin
    off = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = PW'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    win = sum >= NR ? PW'(sum - NR) : sum[PW-1:0];
    nxt = {1'b0, win} + 1'b1;
    gnt = found ? {{(NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    ptr_d = found ? (nxt == NR ? '0 : nxt[PW-1:0]) : ptr_q;
    tag_d = tag_q << NUM_REQ;
    tag_d[0] = gnt;
  end
  // pointer and tag pipeline; reset drops every in-flight tag at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      tag_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
    end
  end
  assign bus.gnt = gnt;
  assign bus.rom_addr = found ? bus.req_addr[win*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bus.rsp_valid = tag_q[RD_LATENCY-1];
  assign bus.rsp_data = bus.rom_rd_data[DATA_WIDTH-1:0];
  assign bus.busy = |tag_q;
  assign bus.rom_clk_en = found | (|tag_q);
  assign bus.rom_rd_oce = (RD_LATENCY > 1) && (|tag_q[0]);
endmodule
